tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, meaning the number of parallel output channels per frame (legal 2..16).
REQ-002 SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port sync, input, 1, a frame-start strobe sampled on clock.
REQ-005 SHALL have port din, input, 1, the serial time-multiplexed data line.
REQ-006 SHALL have port din_valid, input, 1, qualifying din for the current slot.
REQ-007 SHALL have port dout, output, CHANNELS, the registered parallel frame, with bit k holding slot k.
REQ-008 SHALL have port dout_valid, output, 1, a one-cycle pulse when dout updates.
REQ-009 SHALL have port busy, output, 1, high while a frame is being collected.
REQ-010 SHALL have port parity_err, output, 1, present only under TDM_DEMUX_PARITY_EN.

Function
REQ-011 SHALL implement states IDLE, COLLECT, and (macro only) PARITY.
REQ-012 SHALL move from IDLE to COLLECT on sync, with slot counter = 0; din on the sync cycle is ignored.
REQ-013 SHALL, in COLLECT, on each din_valid cycle store din into shadow bit [slot] and increment slot.
REQ-014 SHALL hold slot and shadow unchanged on cycles with din_valid low (gaps allowed, no timeout).
REQ-015 SHALL, on capture of slot CHANNELS-1, load dout from shadow (including that bit) and pulse dout_valid the following cycle, then return to IDLE (or go to PARITY).
REQ-016 SHALL give latency of one clock from the last-slot valid edge to dout/dout_valid visible.
REQ-017 SHALL treat sync in COLLECT or PARITY as abort-and-restart: discard shadow, slot = 0, stay or return to COLLECT, no dout_valid.
REQ-018 SHALL give sync priority when it coincides with din_valid; that din is dropped.
REQ-019 SHALL accept sync in the same cycle dout_valid is high, starting the next frame with no dead cycle.
REQ-020 SHALL hold dout stable between dout_valid pulses; partial frames never reach dout.
REQ-021 SHALL drive busy high exactly in COLLECT and PARITY.
REQ-022 SHALL size the slot counter to $clog2(CHANNELS+1) and never wrap past CHANNELS-1.

Reset
REQ-023 SHALL, on reset assertion, immediately force state IDLE, slot 0, shadow 0, dout 0, dout_valid 0, busy 0, parity_err 0.
REQ-024 SHALL discard any in-progress frame on reset mid-frame, with no dout_valid after release.
REQ-025 SHALL honour sync on the first clock edge after reset deasserts.

Configuration
REQ-026 SHALL use the macro TDM_DEMUX_PARITY_EN.
REQ-027 SHALL, when the macro is defined, expect one extra valid slot after slot CHANNELS-1 carrying even parity over the frame. PARITY state captures it; dout/dout_valid update as in REQ-015 after the parity slot; parity_err is registered with dout and holds until the next dout_valid.
REQ-028 SHALL, when the macro is undefined, have no PARITY state and no parity_err port, with behaviour exactly per REQ-011..022.

Structure
REQ-029 SHALL place the state enum (IDLE/COLLECT/PARITY) and MAX_CHANNELS=16 in the shared package tdm_demux_pkg.
REQ-030 SHALL instantiate one sub-module, slot_decoder: a one-hot decode of slot gated by din_valid, producing per-channel shadow write enables (the 1-to-N demux).

Verification
REQ-031 SHALL be verified with CHANNELS=8: sync, then valid bits 1,0,1,1,0,0,1,0 -> dout=0x4D, dout_valid one cycle, one clock after the 8th bit.
REQ-032 SHALL be verified with the same frame, din_valid low for 3 cycles between slots 3 and 4 -> dout=0x4D, busy high throughout.
REQ-033 SHALL be verified with sync, 5 bits, sync, then 8 bits all 1 -> no pulse after the partial frame, dout=0xFF once.
REQ-034 SHALL be verified with reset asserted after slot 4, then a new frame 0x0F -> dout 0 during reset, next dout=0x0F, exactly one pulse.
REQ-035 SHALL be verified with sync in the dout_valid cycle, then frame 0xA5 -> back-to-back frames 0x4D, 0xA5 captured.
REQ-036 SHALL be verified, with macro on, with frame 0x4D plus parity bit 1 -> parity_err=1; with parity 0 -> parity_err=0.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared definitions for the TDM demultiplexer.
//   state_t      - frame-collection FSM states (PARITY is only reachable
//                  when TDM_DEMUX_PARITY_EN is defined)
//   MAX_CHANNELS - upper bound on the CHANNELS parameter
package tdm_demux_pkg;

  localparam int MAX_CHANNELS = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_demux_slot_decoder.sv
// slot_decoder: 1-to-N demux of the slot counter into per-channel shadow
// write enables.
//   slot - current slot index
//   en   - qualifies the decode (valid data captured this cycle)
//   we   - one-hot write enables, all zero when en is low
module slot_decoder #(
  parameter int CHANNELS = 8,
  parameter int SLOT_W   = 4
) (
  input  logic [SLOT_W-1:0]   slot,
  input  logic                en,
  output logic [CHANNELS-1:0] we
);

  always_comb begin
    we = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      we[i] = en && (slot == SLOT_W'(i));
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: collects a serial time-multiplexed bit stream into a parallel
// frame of CHANNELS bits (slot k -> dout[k]).
//   clock, reset   - rising-edge clock, asynchronous active-high reset
//   sync           - frame-start strobe; restarts collection from any state
//   din, din_valid - serial data and its per-slot qualifier
//   dout           - registered frame, updated only on complete frames
//   dout_valid     - one-cycle pulse when dout updates
//   busy           - high while a frame is being collected
//   parity_err     - (TDM_DEMUX_PARITY_EN only) even-parity check result of
//                    the extra slot following slot CHANNELS-1
// Optional feature macro: TDM_DEMUX_PARITY_EN.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int CHANNELS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sync,
  input  logic                din,
  input  logic                din_valid,
  output logic [CHANNELS-1:0] dout,
  output logic                dout_valid,
  output logic                busy
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int SW = $clog2(CHANNELS + 1);
  localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

  if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("tdm_demux: CHANNELS out of range");
  end

  state_t              state, state_nxt;
  logic [SW-1:0]       slot, slot_nxt;
  logic [CHANNELS-1:0] shadow, shadow_nxt;
  logic [CHANNELS-1:0] we;
  logic [CHANNELS-1:0] captured;
  logic                wr_en;
  logic                dout_load;

  // sync has priority over a coincident valid bit, so it also blocks the write.
  assign wr_en = (state == COLLECT) && din_valid && !sync;

  slot_decoder #(
    .CHANNELS (CHANNELS),
    .SLOT_W   (SW)
  ) u_slot_decoder (
    .slot (slot),
    .en   (wr_en),
    .we   (we)
  );

  assign captured = (shadow & ~we) | (we & {CHANNELS{din}});
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    shadow_nxt = shadow;
    dout_load  = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_nxt  = COLLECT;
          slot_nxt   = '0;
          shadow_nxt = '0;
        end
      end
      COLLECT: begin
        if (sync) begin
          slot_nxt   = '0;
          shadow_nxt = '0;
        end else if (din_valid) begin
          shadow_nxt = captured;
          if (slot == LAST) begin
            slot_nxt = '0;
`ifdef TDM_DEMUX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = IDLE;
            dout_load = 1'b1;
`endif
          end else begin
            slot_nxt = slot + SW'(1);
          end
        end
      end
`ifdef TDM_DEMUX_PARITY_EN
      PARITY: begin
        if (sync) begin
          state_nxt  = COLLECT;
          slot_nxt   = '0;
          shadow_nxt = '0;
        end else if (din_valid) begin
          state_nxt = IDLE;
          dout_load = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      slot       <= '0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      shadow     <= shadow_nxt;
      dout_valid <= dout_load;
      // shadow_nxt already includes the last data bit when it is captured
      // in the same cycle as the load.
      if (dout_load) dout <= shadow_nxt;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Even parity: frame bits plus parity bit must contain an even number of ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (dout_load) begin
      parity_err <= (^shadow) ^ din;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux with CHANNELS=8.
module tb_tdm_demux;

  localparam int CH = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sync = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic [CH-1:0] dout;
  logic          dout_valid;
  logic          busy;
`ifdef TDM_DEMUX_PARITY_EN
  logic          parity_err;
`endif

  tdm_demux #(.CHANNELS(CH)) dut (
    .clock      (clock),
    .reset      (reset),
    .sync       (sync),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [CH-1:0] d;
    logic          pe;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every dout_valid pulse must match the oldest expected frame.
  always @(negedge clock) begin
    if (!reset && dout_valid) begin
      if (expq.size() == 0) begin
        check("unexpected_pulse", 32'(dout), 32'hDEAD);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("frame_dout", 32'(dout), 32'(e.d));
`ifdef TDM_DEMUX_PARITY_EN
        check("frame_parity_err", 32'(parity_err), 32'(e.pe));
`endif
      end
    end
  end

  // All drivers change inputs 1ns after a rising edge and return there.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    sync = 1'b0; din_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_sync(input logic v, input logic b);
    sync = 1'b1; din_valid = v; din = b;
    step();
    sync = 1'b0; din_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sync = 1'b0; din_valid = 1'b1; din = b;
    step();
    din_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [CH-1:0] d, input int first, input int last);
    for (int i = first; i <= last; i++) send_bit(d[i]);
  endtask

  // Full frame: sync, CH data bits, then the parity slot when enabled.
  task automatic send_frame(input logic [CH-1:0] d, input logic p);
    exp_t e;
    e.d  = d;
    e.pe = (^d) ^ p;
    expq.push_back(e);
    do_sync(1'b0, 1'b0);
    send_bits(d, 0, CH - 1);
`ifdef TDM_DEMUX_PARITY_EN
    send_bit(p);
`endif
  endtask

  initial begin
    // Reset state
    step();
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_dout_valid", 32'(dout_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
`ifdef TDM_DEMUX_PARITY_EN
    check("reset_parity_err", 32'(parity_err), 32'h0);
`endif

    // Frame 0x4D with sync on the first edge after reset release; parity 1 is odd
    reset = 1'b0;
    send_frame(8'h4D, 1'b1);
    check("latency_pulse", 32'(dout_valid), 32'h1);
    check("latency_dout", 32'(dout), 32'h4D);
    idle(1);
    check("pulse_one_cycle", 32'(dout_valid), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    idle(1);

    // Same frame with a 3-cycle gap between slots 3 and 4
    begin
      exp_t e;
      e.d = 8'h4D; e.pe = 1'b0;
      expq.push_back(e);
    end
    do_sync(1'b0, 1'b0);
    check("busy_after_sync", 32'(busy), 32'h1);
    send_bits(8'h4D, 0, 3);
    for (int g = 0; g < 3; g++) begin
      din = 1'b1;
      idle(1);
      check("busy_in_gap", 32'(busy), 32'h1);
    end
    send_bits(8'h4D, 4, 7);
`ifdef TDM_DEMUX_PARITY_EN
    send_bit(1'b0);
`endif
    idle(2);

    // Partial frame aborted by sync, then all ones
    do_sync(1'b0, 1'b0);
    send_bits(8'hFF, 0, 4);
    send_frame(8'hFF, 1'b0);
    idle(2);

    // Reset mid-frame after slot 4, then frame 0x0F
    do_sync(1'b0, 1'b0);
    send_bits(8'hFF, 0, 4);
    reset = 1'b1;
    #2;
    check("reset_mid_dout", 32'(dout), 32'h0);
    check("reset_mid_busy", 32'(busy), 32'h0);
    step();
    step();
    reset = 1'b0;
    idle(2);
    check("no_pulse_after_reset", 32'(dout_valid), 32'h0);
    send_frame(8'h0F, 1'b0);
    idle(2);

    // Back-to-back: sync issued in the dout_valid cycle
    send_frame(8'h4D, 1'b0);
    check("b2b_pulse", 32'(dout_valid), 32'h1);
    send_frame(8'hA5, 1'b0);
    idle(2);

    // sync coinciding with din_valid drops that bit
    do_sync(1'b1, 1'b1);
    begin
      exp_t e;
      e.d = 8'h3C; e.pe = 1'b0;
      expq.push_back(e);
    end
    send_bits(8'h3C, 0, 7);
`ifdef TDM_DEMUX_PARITY_EN
    send_bit(1'b0);
`endif
    idle(1);

    // Valid data in IDLE must not disturb dout
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    idle(1);
    check("idle_dout_stable", 32'(dout), 32'h3C);
    check("idle_no_busy", 32'(busy), 32'h0);

    idle(3);
    check("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
